// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side inputs, forwarding taps from MEM/WB and the
// registered EX-side outputs. The pipeline controller drives the master side.
interface id_ex_stage_if;
   logic        stall;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic [4:0]  mem_rd;
   logic [4:0]  wb_rd;
   logic        mem_reg_write;
   logic        wb_reg_write;
   logic [31:0] mem_result;
   logic [31:0] wb_result;
   logic        ex_valid;
   logic [31:0] ex_A;
   logic [31:0] ex_B;
   logic [3:0]  ex_ALUControl;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_illegal;

   modport master (
      output stall, flush, id_valid, id_instr, id_pc, id_rs1_data, id_rs2_data,
             id_imm, mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_result,
             wb_result,
      input  ex_valid, ex_A, ex_B, ex_ALUControl, ex_rd, ex_reg_write, ex_illegal
   );

   modport slave (
      input  stall, flush, id_valid, id_instr, id_pc, id_rs1_data, id_rs2_data,
             id_imm, mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_result,
             wb_result,
      output ex_valid, ex_A, ex_B, ex_ALUControl, ex_rd, ex_reg_write, ex_illegal
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for an RV32I-style core: decodes the ALU operation,
// operand sources and write-enable, registers them with flush/stall control,
// and presents ALU operands selected (and optionally forwarded) after the
// register. Optional feature macro: FORWARDING_EN enables MEM/WB operand
// forwarding and refresh of held operands from WB while stalled.
module id_ex_stage (
   input  logic         clk,
   input  logic         rst_n,
   id_ex_stage_if.slave bus
);
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1001;

   typedef enum logic [1:0] {A_RS1, A_ZERO, A_PC}  asel_t;
   typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} bsel_t;

   // funct3 -> ALU code; funct7[5] picks sub (register form only) or sra.
   function automatic logic [3:0] f3_to_alu(input logic [2:0] f3,
                                            input logic       alt,
                                            input logic       is_reg);
      case (f3)
         3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
         3'b001:  return 4'b0001;
         3'b010:  return 4'b0010;
         3'b011:  return 4'b0011;
         3'b100:  return 4'b0100;
         3'b101:  return alt ? 4'b0110 : 4'b0101;
         3'b110:  return 4'b0111;
         default: return 4'b1000;
      endcase
   endfunction

   logic [6:0]  w_opc;
   logic [3:0]  w_alu;
   logic        w_we;
   logic        w_ill;
   asel_t       w_asel;
   bsel_t       w_bsel;

   logic        r_vld_p1;
   logic        r_we_p1;
   logic        r_ill_p1;
   logic [3:0]  r_alu_p1;
   logic [4:0]  r_rd_p1;
   logic [4:0]  r_rs1_p1;
   logic [4:0]  r_rs2_p1;
   logic [31:0] r_rs1_data_p1;
   logic [31:0] r_rs2_data_p1;
   logic [31:0] r_pc_p1;
   logic [31:0] r_imm_p1;
   asel_t       r_asel_p1;
   bsel_t       r_bsel_p1;

   logic [31:0] w_src1;
   logic [31:0] w_src2;

   assign w_opc = bus.id_instr[6:0];

   // Decode ALU operation, operand sources and write-enable from the ID instruction.
   // Unsupported opcodes keep the rs1/rs2 operand selection so nothing else changes.
   always_comb begin
      w_alu  = ALU_ADD;
      w_we   = 1'b0;
      w_ill  = 1'b0;
      w_asel = A_RS1;
      w_bsel = B_RS2;
      case (w_opc)
         OPC_OP: begin
            w_alu = f3_to_alu(bus.id_instr[14:12], bus.id_instr[30], 1'b1);
            w_we  = 1'b1;
         end
         OPC_OPIMM: begin
            w_alu  = f3_to_alu(bus.id_instr[14:12], bus.id_instr[30], 1'b0);
            w_we   = 1'b1;
            w_bsel = B_IMM;
         end
         OPC_LOAD: begin
            w_we   = 1'b1;
            w_bsel = B_IMM;
         end
         OPC_STORE: begin
            w_bsel = B_IMM;
         end
         OPC_LUI: begin
            w_we   = 1'b1;
            w_asel = A_ZERO;
            w_bsel = B_IMM;
         end
         OPC_AUIPC: begin
            w_we   = 1'b1;
            w_asel = A_PC;
            w_bsel = B_IMM;
         end
         OPC_JAL, OPC_JALR: begin
            w_we   = 1'b1;
            w_asel = A_PC;
            w_bsel = B_FOUR;
         end
         OPC_BRANCH: begin
            w_alu = ALU_SUB;
         end
         default: begin
            w_ill = 1'b1;
         end
      endcase
   end

   // EX stage register: flush inserts a bubble, stall holds, otherwise capture ID.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1      <= 1'b0;
         r_we_p1       <= 1'b0;
         r_ill_p1      <= 1'b0;
         r_alu_p1      <= 4'b0000;
         r_rd_p1       <= 5'd0;
         r_rs1_p1      <= 5'd0;
         r_rs2_p1      <= 5'd0;
         r_rs1_data_p1 <= 32'd0;
         r_rs2_data_p1 <= 32'd0;
         r_pc_p1       <= 32'd0;
         r_imm_p1      <= 32'd0;
         r_asel_p1     <= A_RS1;
         r_bsel_p1     <= B_RS2;
      end else if (bus.flush) begin
         r_vld_p1 <= 1'b0;
         r_we_p1  <= 1'b0;
         r_ill_p1 <= 1'b0;
      end else if (bus.stall) begin
`ifdef FORWARDING_EN
         // A held operand whose producer retires from WB now would otherwise be lost.
         if (r_asel_p1 == A_RS1 && bus.wb_reg_write &&
             bus.wb_rd == r_rs1_p1 && r_rs1_p1 != 5'd0)
            r_rs1_data_p1 <= bus.wb_result;
         if (r_bsel_p1 == B_RS2 && bus.wb_reg_write &&
             bus.wb_rd == r_rs2_p1 && r_rs2_p1 != 5'd0)
            r_rs2_data_p1 <= bus.wb_result;
`endif
      end else begin
         r_vld_p1      <= bus.id_valid;
         r_we_p1       <= w_we;
         r_ill_p1      <= w_ill;
         r_alu_p1      <= w_alu;
         r_rd_p1       <= bus.id_instr[11:7];
         r_rs1_p1      <= bus.id_instr[19:15];
         r_rs2_p1      <= bus.id_instr[24:20];
         r_rs1_data_p1 <= bus.id_rs1_data;
         r_rs2_data_p1 <= bus.id_rs2_data;
         r_pc_p1       <= bus.id_pc;
         r_imm_p1      <= bus.id_imm;
         r_asel_p1     <= w_asel;
         r_bsel_p1     <= w_bsel;
      end
   end

   // Register operand values: MEM result beats WB result beats captured data; x0 never forwards.
   always_comb begin
      w_src1 = r_rs1_data_p1;
      w_src2 = r_rs2_data_p1;
`ifdef FORWARDING_EN
      if (bus.mem_reg_write && bus.mem_rd == r_rs1_p1 && r_rs1_p1 != 5'd0)
         w_src1 = bus.mem_result;
      else if (bus.wb_reg_write && bus.wb_rd == r_rs1_p1 && r_rs1_p1 != 5'd0)
         w_src1 = bus.wb_result;
      if (bus.mem_reg_write && bus.mem_rd == r_rs2_p1 && r_rs2_p1 != 5'd0)
         w_src2 = bus.mem_result;
      else if (bus.wb_reg_write && bus.wb_rd == r_rs2_p1 && r_rs2_p1 != 5'd0)
         w_src2 = bus.wb_result;
`endif
   end

`ifndef FORWARDING_EN
   logic w_unused_fwd;
   assign w_unused_fwd = ^{bus.mem_rd, bus.wb_rd, bus.mem_reg_write, bus.wb_reg_write,
                           bus.mem_result, bus.wb_result, r_rs1_p1, r_rs2_p1};
`endif
   logic w_unused_instr;
   assign w_unused_instr = ^{bus.id_instr[31], bus.id_instr[29:25]};

   // Final operand muxes by the registered source selects.
   always_comb begin
      case (r_asel_p1)
         A_ZERO:  bus.ex_A = 32'd0;
         A_PC:    bus.ex_A = r_pc_p1;
         default: bus.ex_A = w_src1;
      endcase
      case (r_bsel_p1)
         B_IMM:   bus.ex_B = r_imm_p1;
         B_FOUR:  bus.ex_B = 32'd4;
         default: bus.ex_B = w_src2;
      endcase
   end

   assign bus.ex_valid      = r_vld_p1;
   assign bus.ex_reg_write  = r_vld_p1 & r_we_p1;
   assign bus.ex_illegal    = r_ill_p1;
   assign bus.ex_ALUControl = r_alu_p1;
   assign bus.ex_rd         = r_rd_p1;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: a vector table for single-cycle decode
// plus hand sequences for forwarding, stall refresh, flush and reset.
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input string name, input logic valid, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [31:0] rs1d,
                          input logic [31:0] rs2d, input logic [31:0] imm,
                          input logic [3:0] alu, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic rw, input logic ill);
      vec_t v;
      v.name = name; v.valid = valid; v.instr = instr; v.pc = pc;
      v.rs1d = rs1d; v.rs2d = rs2d; v.imm = imm; v.alu = alu;
      v.a = a; v.b = b; v.rd = rd; v.rw = rw; v.ill = ill;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_id(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] rs1d, input logic [31:0] rs2d,
                           input logic [31:0] imm);
      bus.id_valid    = valid;
      bus.id_instr    = instr;
      bus.id_pc       = pc;
      bus.id_rs1_data = rs1d;
      bus.id_rs2_data = rs2d;
      bus.id_imm      = imm;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " valid"}, {31'd0, bus.ex_valid}, 32'd0);
      chk({tag, " reg_write"}, {31'd0, bus.ex_reg_write}, 32'd0);
      chk({tag, " illegal"}, {31'd0, bus.ex_illegal}, 32'd0);
      chk({tag, " alu"}, {28'd0, bus.ex_ALUControl}, 32'd0);
      chk({tag, " rd"}, {27'd0, bus.ex_rd}, 32'd0);
      chk({tag, " A"}, bus.ex_A, 32'd0);
      chk({tag, " B"}, bus.ex_B, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.stall = 1'b0; bus.flush = 1'b0;
      bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
      bus.mem_reg_write = 1'b0; bus.wb_reg_write = 1'b0;
      bus.mem_result = 32'd0; bus.wb_result = 32'd0;
      drive_id(1'b1, 32'h002081B3, 32'h40, 32'h5, 32'h7, 32'h0);

      //        name     vld instr          pc         rs1d        rs2d   imm          alu    A            B            rd rw ill
      add_vec("add",    1, 32'h002081B3, 32'h0,   32'h5,      32'h7,  32'h0,        4'h0, 32'h5,      32'h7,        3, 1, 0);
      add_vec("sub",    1, 32'h402081B3, 32'h0,   32'd20,     32'd8,  32'h0,        4'h9, 32'd20,     32'd8,        3, 1, 0);
      add_vec("srai",   1, 32'h4032D213, 32'h0,   32'h80,     32'h55, 32'h403,      4'h6, 32'h80,     32'h403,      4, 1, 0);
      add_vec("addi7",  1, 32'h40010093, 32'h0,   32'h10,     32'h0,  32'h400,      4'h0, 32'h10,     32'h400,      1, 1, 0);
      add_vec("slti",   1, 32'h0000A113, 32'h0,   32'h3,      32'h0,  32'h5,        4'h2, 32'h3,      32'h5,        2, 1, 0);
      add_vec("sltu",   1, 32'h00003033, 32'h0,   32'h1,      32'h2,  32'h0,        4'h3, 32'h1,      32'h2,        0, 1, 0);
      add_vec("xori",   1, 32'h00004293, 32'h0,   32'hF0,     32'h0,  32'hFF,       4'h4, 32'hF0,     32'hFF,       5, 1, 0);
      add_vec("srl",    1, 32'h00005333, 32'h0,   32'h100,    32'h4,  32'h0,        4'h5, 32'h100,    32'h4,        6, 1, 0);
      add_vec("or",     1, 32'h00006333, 32'h0,   32'h11,     32'h22, 32'h0,        4'h7, 32'h11,     32'h22,       6, 1, 0);
      add_vec("and",    1, 32'h00007333, 32'h0,   32'h33,     32'h44, 32'h0,        4'h8, 32'h33,     32'h44,       6, 1, 0);
      add_vec("sll",    1, 32'h00001333, 32'h0,   32'h1,      32'h3,  32'h0,        4'h1, 32'h1,      32'h3,        6, 1, 0);
      add_vec("lw",     1, 32'h00002283, 32'h0,   32'h1000,   32'h0,  32'h8,        4'h0, 32'h1000,   32'h8,        5, 1, 0);
      add_vec("sw",     1, 32'h00002223, 32'h0,   32'h2000,   32'h77, 32'h4,        4'h0, 32'h2000,   32'h4,        4, 0, 0);
      add_vec("lui",    1, 32'h123453B7, 32'h0,   32'hAAAA,   32'h0,  32'h12345000, 4'h0, 32'h0,      32'h12345000, 7, 1, 0);
      add_vec("auipc",  1, 32'h00001417, 32'h100, 32'h0,      32'h0,  32'h1000,     4'h0, 32'h100,    32'h1000,     8, 1, 0);
      add_vec("jal",    1, 32'h000000EF, 32'h200, 32'h0,      32'h0,  32'h40,       4'h0, 32'h200,    32'h4,        1, 1, 0);
      add_vec("jalr",   1, 32'h000100E7, 32'h300, 32'h5,      32'h0,  32'h0,        4'h0, 32'h300,    32'h4,        1, 1, 0);
      add_vec("beq",    1, 32'h00208063, 32'h0,   32'h9,      32'h9,  32'h10,       4'h9, 32'h9,      32'h9,        0, 0, 0);
      add_vec("illegal",1, 32'h000001FF, 32'h0,   32'h31,     32'h32, 32'h0,        4'h0, 32'h31,     32'h32,       3, 0, 1);
      add_vec("novalid",0, 32'h002081B3, 32'h0,   32'h1,      32'h2,  32'h0,        4'h0, 32'h1,      32'h2,        3, 0, 0);

      // Reset state
      step();
      step();
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Table of single-instruction captures
      foreach (vecs[i]) begin
         drive_id(vecs[i].valid, vecs[i].instr, vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm);
         step();
         chk({vecs[i].name, " valid"}, {31'd0, bus.ex_valid}, {31'd0, vecs[i].valid});
         chk({vecs[i].name, " alu"}, {28'd0, bus.ex_ALUControl}, {28'd0, vecs[i].alu});
         chk({vecs[i].name, " A"}, bus.ex_A, vecs[i].a);
         chk({vecs[i].name, " B"}, bus.ex_B, vecs[i].b);
         chk({vecs[i].name, " rd"}, {27'd0, bus.ex_rd}, {27'd0, vecs[i].rd});
         chk({vecs[i].name, " reg_write"}, {31'd0, bus.ex_reg_write}, {31'd0, vecs[i].rw});
         chk({vecs[i].name, " illegal"}, {31'd0, bus.ex_illegal}, {31'd0, vecs[i].ill});
      end

      // MEM beats WB when both match rs1
      drive_id(1'b1, 32'h402081B3, 32'h0, 32'd20, 32'd8, 32'h0);
      step();
      bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd1; bus.mem_result = 32'd100;
      bus.wb_reg_write  = 1'b1; bus.wb_rd  = 5'd1; bus.wb_result  = 32'd50;
      #1;
      chk("fwd mem prio A", bus.ex_A, FWD ? 32'd100 : 32'd20);
      chk("fwd mem prio B", bus.ex_B, 32'd8);
      bus.mem_reg_write = 1'b0;
      #1;
      chk("fwd wb A", bus.ex_A, FWD ? 32'd50 : 32'd20);
      bus.wb_reg_write = 1'b0;
      #1;
      chk("fwd none A", bus.ex_A, 32'd20);

      // x0 is never forwarded
      drive_id(1'b1, 32'h002001B3, 32'h0, 32'h44, 32'h8, 32'h0);
      bus.stall = 1'b0;
      step();
      bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd0; bus.mem_result = 32'd100;
      bus.wb_reg_write  = 1'b1; bus.wb_rd  = 5'd0; bus.wb_result  = 32'd50;
      #1;
      chk("x0 no fwd A", bus.ex_A, 32'h44);
      bus.mem_reg_write = 1'b0; bus.wb_reg_write = 1'b0;

      // Stall refresh: or x6,x7,x8 held while WB retires x7
      drive_id(1'b1, 32'h0083E333, 32'h0, 32'h1111, 32'h2222, 32'h0);
      step();
      chk("stall cap A", bus.ex_A, 32'h1111);
      bus.stall = 1'b1;
      drive_id(1'b1, 32'h002081B3, 32'h0, 32'h9999, 32'h8888, 32'h0);
      bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd7; bus.wb_result = 32'hDEAD;
      #1;
      chk("stall pulse A", bus.ex_A, FWD ? 32'hDEAD : 32'h1111);
      step();
      bus.wb_reg_write = 1'b0; bus.wb_result = 32'h0;
      #1;
      chk("stall after pulse A", bus.ex_A, FWD ? 32'hDEAD : 32'h1111);
      step();
      chk("stall held A", bus.ex_A, FWD ? 32'hDEAD : 32'h1111);
      chk("stall held B", bus.ex_B, 32'h2222);
      chk("stall held alu", {28'd0, bus.ex_ALUControl}, 32'h7);
      chk("stall held rd", {27'd0, bus.ex_rd}, 32'd6);
      bus.stall = 1'b0;

      // Flush with stall gives a bubble; flush alone too
      drive_id(1'b1, 32'h002081B3, 32'h0, 32'h5, 32'h7, 32'h0);
      step();
      chk("pre-flush valid", {31'd0, bus.ex_valid}, 32'd1);
      drive_id(1'b1, 32'h123453B7, 32'h0, 32'h0, 32'h0, 32'h12345000);
      bus.stall = 1'b1; bus.flush = 1'b1;
      step();
      chk("flush+stall valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("flush+stall reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
      bus.stall = 1'b0; bus.flush = 1'b0;
      step();
      chk("lui after flush valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("lui after flush B", bus.ex_B, 32'h12345000);
      bus.flush = 1'b1;
      step();
      chk("flush valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("flush reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
      bus.flush = 1'b0;

      // Asynchronous reset in the middle of a stall
      drive_id(1'b1, 32'h002081B3, 32'h0, 32'h5, 32'h7, 32'h0);
      step();
      bus.stall = 1'b1;
      step();
      chk("midstall valid", {31'd0, bus.ex_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async reset");
      rst_n = 1'b1;
      bus.stall = 1'b0;
      drive_id(1'b1, 32'h4032D213, 32'h0, 32'h80, 32'h0, 32'h403);
      step();
      chk("post-reset valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("post-reset alu", {28'd0, bus.ex_ALUControl}, 32'h6);
      chk("post-reset A", bus.ex_A, 32'h80);
      chk("post-reset B", bus.ex_B, 32'h403);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  hold all stage registers this cycle.
REQ-005 flush  in  1  replace captured instruction with a bubble.
REQ-006 id_valid  in  1  ID slot holds a real instruction.
REQ-007 id_instr  in  32  raw instruction (opcode, rd, funct3, rs1, rs2, funct7 taken from it).
REQ-008 id_pc  in  32  instruction PC.
REQ-009 id_rs1_data / id_rs2_data  in  32 each  register-file read data.
REQ-010 id_imm  in  32  sign-extended immediate.
REQ-011 mem_rd, wb_rd  in  5 each  destination of MEM / WB stage.
REQ-012 mem_reg_write, wb_reg_write  in  1 each  MEM / WB stage writes its rd.
REQ-013 mem_result, wb_result  in  32 each  MEM / WB result values.
REQ-014 ex_valid  out  1  EX slot valid.
REQ-015 ex_A, ex_B  out  32 each  ALU operands.
REQ-016 ex_ALUControl  out  4  ALU operation code.
REQ-017 ex_rd  out  5  destination register.
REQ-018 ex_reg_write  out  1  equals ex_valid AND decoded write-enable.
REQ-019 ex_illegal  out  1  captured opcode unsupported.

Function
REQ-020 Priority per edge SHALL be flush > stall > capture; flush clears ex_valid and write-enable, stall holds everything, capture latches ID inputs with ex_valid=id_valid.
REQ-021 Latency SHALL be one cycle from ID inputs to registered EX fields; ex_A/ex_B SHALL be combinational from registered state plus forwarding inputs.
REQ-022 ALU codes: 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 0110 sra, 0111 or, 1000 and, 1001 sub, 1010 sge.
REQ-023 OP (0110011): funct3 000 -> add (funct7[5]=0) / sub (=1); 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl/sra by funct7[5]; 110 or; 111 and; A=rs1, B=rs2.
REQ-024 OP-IMM (0010011): same map except 000 always add; B=imm.
REQ-025 LOAD/STORE: add, A=rs1, B=imm; LUI: add, A=0, B=imm; AUIPC: add, A=pc, B=imm; JAL/JALR: add, A=pc, B=4; BRANCH: sub, A=rs1, B=rs2.
REQ-026 Write-enable SHALL be 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR and 0 otherwise.
REQ-027 Any other opcode SHALL set ex_illegal=1, ex_ALUControl=0000, write-enable=0, ex_valid unchanged.
REQ-028 Forwarding applies only where operand source is rs1/rs2: MEM match (mem_reg_write, mem_rd==rsX, rsX!=0) wins over WB match; else captured data.
REQ-029 Register x0 SHALL never be forwarded.
REQ-030 During stall, a WB match on a held rs1/rs2 SHALL overwrite the held operand with wb_result so the value survives retirement.
REQ-031 Flush and stall asserted together SHALL produce a bubble.

Reset
REQ-032 rst_n low SHALL immediately clear all registers: ex_valid=0, ex_reg_write=0, ex_illegal=0, ex_ALUControl=0000, ex_rd=0, captured operands/PC/imm=0.
REQ-033 Reset mid-stall SHALL discard the held instruction; first edge after release captures normally.

Configuration
REQ-034 Macro FORWARDING_EN defined: REQ-028..030 active.
REQ-035 FORWARDING_EN undefined: ex_A/ex_B from captured values only, mem_*/wb_* ignored, no stall refresh.

Verification
REQ-036 add x3,x1,x2 with rs1=5, rs2=7 -> next cycle ex_ALUControl=0000, ex_A=5, ex_B=7, ex_reg_write=1, ex_rd=3.
REQ-037 sub x3,x1,x2 captured; mem_rd=1, mem_result=100, wb_rd=1, wb_result=50 -> ex_A=100 (MEM priority).
REQ-038 srai x4,x5,3 -> ex_ALUControl=0110, ex_B=imm; opcode 1111111 -> ex_illegal=1, ex_reg_write=0.
REQ-039 stall 2 cycles holding or x6,x7,x8 while wb_rd=7, wb_result=0xDEAD pulses once -> ex_A stays 0xDEAD after pulse ends.
REQ-040 flush and stall both high with valid lui -> ex_valid=0; rst_n low mid-stall -> all outputs 0 asynchronously.
